mips_mc_control: RTL and testbench

- Multi-cycle control unit for the next-generation MIPS core; replaces the single-cycle combinational decoder.
- Moore FSM sequences each instruction through fetch/decode/execute/memory/writeback, driving a shared-memory multi-cycle datapath.
- Parametrised memory wait states; supports R-type, lw, sw, beq, addi, j, jal; flags illegal opcodes.

---
 rtl/mips_mc_control.sv | 164 ++++++++++++++++
 tb/tb_mips_mc_control.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control unit: Moore FSM over fetch/decode/execute/memory/
// writeback, with a 4-bit wait counter holding memory states MEM_WAIT extra
// cycles. Optional performance counters behind `MIPS_MC_PERF_EN.
module mips_mc_control #(
  parameter int MEM_WAIT = 0,
  parameter int PERF_W   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  OpCode,
  output logic        PCWrite,
  output logic        Branch,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        JumpLink,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSrc,
  output logic        illegal_op,
  output logic [3:0]  state_o
`ifdef MIPS_MC_PERF_EN
  ,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] instr_cnt
`endif
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11,
    JAL    = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [3:0] WLAST = 4'(MEM_WAIT);

  state_t     state, state_nx;
  logic [3:0] wcnt, wcnt_nx;
  logic       wdone;

  assign wdone = (wcnt == WLAST);

  // State and wait-counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
    end
  end

  // Next state; wait counter only runs inside memory states and is zero elsewhere,
  // so it is already clear on entry to the next memory state
  always_comb begin
    state_nx = state;
    wcnt_nx  = '0;
    case (state)
      FETCH:  if (wdone) state_nx = DECODE; else wcnt_nx = wcnt + 4'd1;
      DECODE: begin
        case (OpCode)
          OP_LW, OP_SW: state_nx = MEMADR;
          OP_R:         state_nx = EXEC;
          OP_BEQ:       state_nx = BRANCH;
          OP_ADDI:      state_nx = ADDIEX;
          OP_J:         state_nx = JUMP;
          OP_JAL:       state_nx = JAL;
          default:      state_nx = FETCH;
        endcase
      end
      MEMADR: state_nx = (OpCode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (wdone) state_nx = MEMWB; else wcnt_nx = wcnt + 4'd1;
      MEMWB:  state_nx = FETCH;
      MEMWR:  if (wdone) state_nx = FETCH; else wcnt_nx = wcnt + 4'd1;
      EXEC:   state_nx = ALUWB;
      ALUWB:  state_nx = FETCH;
      BRANCH: state_nx = FETCH;
      ADDIEX: state_nx = ADDIWB;
      ADDIWB: state_nx = FETCH;
      JUMP:   state_nx = FETCH;
      JAL:    state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
  end

  // Control outputs from registered state; everything forced low while in reset.
  // illegal_op is the one opcode-dependent output: the IR only holds the new
  // opcode during DECODE, so the flag cannot be registered earlier.
  always_comb begin
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    JumpLink   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSrc      = 2'b00;
    illegal_op = 1'b0;
    state_o    = 4'd0;
    if (!reset) begin
      state_o = state;
      case (state)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = wdone;
          PCWrite = wdone;
        end
        DECODE: begin
          ALUSrcB    = 2'b11;
          illegal_op = !(OpCode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL});
        end
        MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
        MEMRD:  begin IorD = 1'b1; MemRead = 1'b1; end
        MEMWB:  begin MemtoReg = 1'b1; RegWrite = 1'b1; end
        MEMWR:  begin IorD = 1'b1; MemWrite = 1'b1; end
        EXEC:   begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
        ALUWB:  begin RegDst = 1'b1; RegWrite = 1'b1; end
        BRANCH: begin ALUSrcA = 1'b1; ALUOp = 2'b01; PCSrc = 2'b01; Branch = 1'b1; end
        ADDIEX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
        ADDIWB: RegWrite = 1'b1;
        JUMP:   begin PCSrc = 2'b10; PCWrite = 1'b1; end
        JAL:    begin PCSrc = 2'b10; PCWrite = 1'b1; JumpLink = 1'b1; RegWrite = 1'b1; end
        default: ;
      endcase
    end
  end

`ifdef MIPS_MC_PERF_EN
  // Cycle and retired-instruction counters; an instruction retires when the FSM
  // returns to FETCH (including the illegal-opcode path)
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (state != FETCH && state_nx == FETCH) instr_cnt <= instr_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: three instances (MEM_WAIT 0, 2, 3) run independent
// instruction streams; a per-instruction sequence model predicts every cycle.
module tb_mips_mc_control;
  localparam int NDUT = 3;

  function automatic int mw_of(int d);
    return (d == 0) ? 0 : (d == 1) ? 2 : 3;
  endfunction

  logic clk = 1'b0;
  logic reset;
  logic [5:0]  op  [NDUT];
  logic [21:0] obs [NDUT];
`ifdef MIPS_MC_PERF_EN
  logic [31:0] cyc_o [NDUT];
  logic [31:0] ins_o [NDUT];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic pcw, br, iord, mr, mwr, irw, m2r, rd, jl, rw, asa, ill;
    logic [1:0] asb, aop, pcs;
    logic [3:0] st;
    mips_mc_control #(.MEM_WAIT(mw_of(g)), .PERF_W(32)) dut (
      .clk(clk), .reset(reset), .OpCode(op[g]),
      .PCWrite(pcw), .Branch(br), .IorD(iord), .MemRead(mr), .MemWrite(mwr),
      .IRWrite(irw), .MemtoReg(m2r), .RegDst(rd), .JumpLink(jl), .RegWrite(rw),
      .ALUSrcA(asa), .ALUSrcB(asb), .ALUOp(aop), .PCSrc(pcs),
      .illegal_op(ill), .state_o(st)
`ifdef MIPS_MC_PERF_EN
      , .cycle_cnt(cyc_o[g]), .instr_cnt(ins_o[g])
`endif
    );
    assign obs[g] = {pcw, br, iord, mr, mwr, irw, m2r, rd, jl, rw, asa, asb, aop, pcs, ill, st};
  end

  int errors = 0;
  int checks = 0;
  logic [21:0] expq [NDUT][$];
  int done_cnt [NDUT];

  // Expected control word for one cycle spent in state st
  function automatic logic [21:0] vec(int st, bit fin, bit ill);
    bit pcw = 0, br = 0, iord = 0, mr = 0, mwr = 0, irw = 0, m2r = 0, rd = 0, jl = 0, rw = 0, asa = 0;
    logic [1:0] asb = 0, aop = 0, pcs = 0;
    case (st)
      0:  begin mr = 1; asb = 1; pcw = fin; irw = fin; end
      1:  asb = 3;
      2:  begin asa = 1; asb = 2; end
      3:  begin iord = 1; mr = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mwr = 1; end
      6:  begin asa = 1; aop = 2; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; aop = 1; pcs = 1; br = 1; end
      9:  begin asa = 1; asb = 2; end
      10: rw = 1;
      11: begin pcs = 2; pcw = 1; end
      12: begin pcs = 2; pcw = 1; jl = 1; rw = 1; end
      default: ;
    endcase
    return {pcw, br, iord, mr, mwr, irw, m2r, rd, jl, rw, asa, asb, aop, pcs, ill, 4'(st)};
  endfunction

  // Queue the full cycle-by-cycle expectation of one instruction
  task automatic push_instr(int d, logic [5:0] o);
    int m = mw_of(d);
    bit legal = o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b000011};
    for (int i = 0; i < m; i++) expq[d].push_back(vec(0, 0, 0));
    expq[d].push_back(vec(0, 1, 0));
    expq[d].push_back(vec(1, 0, !legal));
    case (o)
      6'b100011: begin
        expq[d].push_back(vec(2, 0, 0));
        for (int i = 0; i <= m; i++) expq[d].push_back(vec(3, 0, 0));
        expq[d].push_back(vec(4, 0, 0));
      end
      6'b101011: begin
        expq[d].push_back(vec(2, 0, 0));
        for (int i = 0; i <= m; i++) expq[d].push_back(vec(5, 0, 0));
      end
      6'b000000: begin expq[d].push_back(vec(6, 0, 0)); expq[d].push_back(vec(7, 0, 0)); end
      6'b000100: expq[d].push_back(vec(8, 0, 0));
      6'b001000: begin expq[d].push_back(vec(9, 0, 0)); expq[d].push_back(vec(10, 0, 0)); end
      6'b000010: expq[d].push_back(vec(11, 0, 0));
      6'b000011: expq[d].push_back(vec(12, 0, 0));
      default: ;
    endcase
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] pick_op(int n);
    logic [5:0] tbl [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                            6'b000010, 6'b000011, 6'b001000, 6'b111111};
    int r;
    if (n < 8) return tbl[n];
    r = $urandom_range(0, 7);
    if (r == 7) return 6'($urandom);
    return tbl[r];
  endfunction

  int ninstr [NDUT];

  // One checked cycle for every instance: refill, compare, pop
  task automatic step(int k);
    #1;
    for (int d = 0; d < NDUT; d++) begin
`ifdef MIPS_MC_PERF_EN
      chk($sformatf("cyc%0d", d), cyc_o[d], 32'(k));
      chk($sformatf("ins%0d", d), ins_o[d], 32'(done_cnt[d]));
`endif
      if (expq[d].size() == 0) begin
        op[d] = pick_op(ninstr[d]);
        ninstr[d]++;
        push_instr(d, op[d]);
        #0;
      end
    end
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("ctl%0d op=%b", d, op[d]), 32'(obs[d]), 32'(expq[d][0]));
      void'(expq[d].pop_front());
      if (expq[d].size() == 0) done_cnt[d]++;
    end
  endtask

  initial begin
    int k, hit;
    reset = 1'b1;
    for (int d = 0; d < NDUT; d++) begin op[d] = 6'b000000; ninstr[d] = 0; done_cnt[d] = 0; end
    // Outputs held low through reset, even with an opcode present
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      for (int d = 0; d < NDUT; d++) chk($sformatf("rst%0d", d), 32'(obs[d]), 32'd0);
    end
    reset = 1'b0;
    for (k = 0; k < 400; k++) begin
      step(k);
      @(posedge clk); @(negedge clk);
    end

    // Reset in the middle of a store on the MEM_WAIT=3 instance
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      expq[d].delete(); done_cnt[d] = 0; ninstr[d] = 100;
      op[d] = 6'b101011; push_instr(d, op[d]);
    end
    hit = 0;
    for (k = 0; k < 20 && hit < 2; k++) begin
      if (expq[2][0][3:0] == 4'd5) hit++;
      step(k);
      @(posedge clk); @(negedge clk);
    end
    chk("reach_memwr", 32'(hit), 32'd2);
    reset = 1'b1;
    #1;
    chk("memwr_rst_now", 32'(obs[2]), 32'd0);
    @(posedge clk); @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("midrst%0d", d), 32'(obs[d]), 32'd0);
`ifdef MIPS_MC_PERF_EN
      chk($sformatf("cyc_clr%0d", d), cyc_o[d], 32'd0);
      chk($sformatf("ins_clr%0d", d), ins_o[d], 32'd0);
`endif
    end
    reset = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++)
      chk($sformatf("fetch_after%0d", d), 32'(obs[d]), 32'(vec(0, mw_of(d) == 0, 0)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
